stage_wb_mp: RTL and testbench
==============================

# stage_wb_mp

Parametrised multi-lane writeback stage for the br32 pipeline, successor to the single-lane writeback stage. It registers up to `LANES` retiring results per cycle from the memory stage, commits them to an integrated multi-port register file with same-cycle read bypass, and updates the compare register. It also exports registered lane state for forwarding and maintains a 64-bit retired-instruction counter. It sits after the memory stage and feeds the decode/execute read ports.

## Interface
- `XLEN`, 32, data and PC width
- `NREGS`, 32, architectural registers; power of two; `RW = $clog2(NREGS)`
- `LANES`, 2, writeback lanes; lane index order equals program order, with the higher index younger
- `RPORTS`, 4, combinational register read ports
- `CRW`, 2, compare register width
- `clk`  in  1  pipeline clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  squashes all lanes being captured this cycle
- `mem_bubble`  in  `[LANES]`  lane carries no instruction
- `mem_pc`  in  `[LANES][XLEN]`  lane PC
- `mem_res`  in  `[LANES][XLEN]`  lane result
- `mem_rd`  in  `[LANES][RW]`  destination register
- `mem_w_rd`  in  `[LANES]`  lane writes `rd`
- `mem_w_cr`  in  `[LANES]`  lane writes the compare register
- `mem_cmp_res`  in  `[LANES][CRW]`  compare result
- `wb_bubble`  out  `[LANES]`  registered lane bubble
- `wb_pc`, `wb_res`, `wb_rd`  out  per lane  registered copies
- `wb_w_rd`  out  `[LANES]`  qualified write enable: `w_rd && !bubble && rd != 0`
- `rd_addr`  in  `[RPORTS][RW]`  read addresses
- `rd_data`  out  `[RPORTS][XLEN]`  read data, bypassed
- `cmp_reg`  out  `CRW`  compare register
- `instret`  out  64  retired-instruction count

## Operation
- **Capture.** At each posedge, every lane is latched from `mem_*` into the WB registers. An effective bubble is `mem_bubble | flush`.
- **Commit.** At each posedge, every lane with `wb_w_rd` set writes `wb_res` to `regs[wb_rd]`.
  - If several lanes target the same `rd`, the highest lane index wins.
- **Register 0.** Never written. Reads of address 0 return 0.
- **Read and bypass.** `rd_data[p]` is combinational.
  - If any lane has `wb_w_rd` set with `wb_rd == rd_addr[p]` and a nonzero address, the result comes from the highest such lane.
  - Otherwise it is `regs[rd_addr[p]]`.
  - A read therefore observes the value committed at the end of the same cycle.
- **Compare register.** Updated directly from the `mem_*` inputs at the capture edge, one cycle ahead of the regfile commit.
  - The highest lane with `mem_w_cr && !mem_bubble && !flush` supplies `cmp_res`.
  - If no lane qualifies, `cmp_reg` holds.
- **Retire counter.** `instret += popcount(!wb_bubble)` each cycle and wraps modulo 2^64. Lanes with `wb_bubble` set do not count, so squashed instructions are never counted.
- **Flush.** Affects only capture and the compare-register update. Lanes already in WB still commit and retire.

## Timing
- MEM to WB registers: 1 cycle. WB registers to regfile: commit at the following edge, so a result is architecturally visible 2 edges after it is presented on `mem_*`.
- Through bypass, the value is readable 1 cycle after capture, combinationally.
- Reset, asynchronous while `rst_n = 0`:
  - `wb_bubble` all 1.
  - `wb_pc`, `wb_res`, `wb_rd`, `wb_w_rd` all 0.
  - All `regs` 0, `cmp_reg` 0, `instret` 0.
- Reset mid-operation discards in-flight lanes, with no commit. The first capture occurs at the first posedge after `rst_n` rises.
- Simultaneous `flush` and `mem_w_cr` on the same cycle: no compare-register update.
- `LANES = 1` must behave exactly like the single-lane stage, plus reset and `instret`.

## Structure
- Shared package `br32_wb_pkg`:
  - `wb_lane_t` struct holding `pc`, `res`, `rd`, `w_rd`, `bubble`.
  - `RW`-derived widths.
  - Function `lane_pick` returning the highest-priority matching lane.
- Sub-module `regfile_mp`, parametrised by `XLEN`, `NREGS`, `LANES`, `RPORTS`. It owns the storage, the write priority, the x0 rule and the read bypass.
- `stage_wb_mp` owns the lane registers, `cmp_reg` and `instret`.

## Test plan
1. **Reset.** Release `rst_n`, then read all registers. Expect `rd_data` = 0, `instret` = 0, `cmp_reg` = 0, `wb_bubble` all ones.
2. **Single write and bypass.** Lane0 presents `rd=5`, `res=0xDEADBEEF`. One cycle later `rd_addr=5` returns `0xDEADBEEF` via bypass; after the next edge it returns the same from `regs`.
3. **Write conflict.** Lane0 and lane1 both target `rd=7`, with `0x11` and `0x22`. Expect `regs[7]=0x22`, and the bypass also returns `0x22`.
4. **x0 rule.** Lane1 presents `rd=0`, `res=0x1234`, `w_rd=1`. Expect `wb_w_rd[1]=0` and reads of address 0 return 0. `instret` still increments by 1.
5. **Flush.** Assert `flush` with both lanes valid, lane1 `w_cr=1`, `cmp=2`. Expect no register change, `cmp_reg` unchanged, and `instret` unchanged one cycle later.
6. **Counter wrap.** Force `instret` to 2^64-1, then retire 2 lanes. Expect `instret = 1`.

Source files
------------

// File: rtl/br32_wb_pkg.sv
// br32_wb_pkg: shared widths, lane record and priority helper for the multi-lane writeback stage
package br32_wb_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_RW    = $clog2(DEF_NREGS);
  localparam int MAX_LANES = 32;
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] res;
    logic [DEF_RW-1:0]   rd;
    logic                w_rd;
    logic                bubble;
  } wb_lane_t;
  function automatic int lane_pick(input logic [MAX_LANES-1:0] mask);
    lane_pick = -1;
    for (int i = 0; i < MAX_LANES; i++) if (mask[i]) lane_pick = i;
  endfunction
endpackage

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with youngest-lane write priority, hardwired x0 and read bypass
module regfile_mp
  import br32_wb_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int LANES  = 2,
  parameter int RPORTS = 4,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES-1:0]             we,
  input  logic [LANES-1:0][RW-1:0]     wa,
  input  logic [LANES-1:0][XLEN-1:0]   wd,
  input  logic [RPORTS-1:0][RW-1:0]    ra,
  output logic [RPORTS-1:0][XLEN-1:0]  rdata
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [RPORTS-1:0][LANES-1:0] hit;
  // Lanes applied in program order so the youngest writer of an rd wins; x0 pinned to zero
  always_comb begin
    regs_d = regs_q;
    for (int l = 0; l < LANES; l++) if (we[l] && wa[l] != '0) regs_d[wa[l]] = wd[l];
    regs_d[0] = '0;
  end
  // Storage; reset clears every register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    else regs_q <= regs_d;
  end
  // Per read port, which lanes are writing the addressed nonzero register this cycle
  always_comb begin
    hit = '0;
    for (int p = 0; p < RPORTS; p++)
      for (int l = 0; l < LANES; l++)
        hit[p][l] = we[l] && wa[l] == ra[p] && ra[p] != '0;
  end
  // Bypass from the youngest hitting lane, else the stored value (x0 reads its zero entry)
  always_comb begin
    rdata = '0;
    for (int p = 0; p < RPORTS; p++) begin
      rdata[p] = regs_q[ra[p]];
      for (int l = 0; l < LANES; l++) if (l == lane_pick(32'(hit[p]))) rdata[p] = wd[l];
    end
  end
endmodule

// File: rtl/stage_wb_mp.sv
// stage_wb_mp: multi-lane writeback stage with lane registers, compare register and retire counter
module stage_wb_mp
  import br32_wb_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int LANES  = 2,
  parameter int RPORTS = 4,
  parameter int CRW    = 2,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [LANES-1:0]             mem_bubble,
  input  logic [LANES-1:0][XLEN-1:0]   mem_pc,
  input  logic [LANES-1:0][XLEN-1:0]   mem_res,
  input  logic [LANES-1:0][RW-1:0]     mem_rd,
  input  logic [LANES-1:0]             mem_w_rd,
  input  logic [LANES-1:0]             mem_w_cr,
  input  logic [LANES-1:0][CRW-1:0]    mem_cmp_res,
  output logic [LANES-1:0]             wb_bubble,
  output logic [LANES-1:0][XLEN-1:0]   wb_pc,
  output logic [LANES-1:0][XLEN-1:0]   wb_res,
  output logic [LANES-1:0][RW-1:0]     wb_rd,
  output logic [LANES-1:0]             wb_w_rd,
  input  logic [RPORTS-1:0][RW-1:0]    rd_addr,
  output logic [RPORTS-1:0][XLEN-1:0]  rd_data,
  output logic [CRW-1:0]               cmp_reg,
  output logic [63:0]                  instret
);
  logic [LANES-1:0]           bubble_q, bubble_d, w_rd_q, w_rd_d;
  logic [LANES-1:0][XLEN-1:0] pc_q, pc_d, res_q, res_d;
  logic [LANES-1:0][RW-1:0]   rd_q, rd_d;
  logic [CRW-1:0]             cmp_q, cmp_d;
  logic [63:0]                instret_q, instret_d;
  // Capture: flush squashes every incoming lane; write enable pre-qualified against bubble and x0
  always_comb begin
    bubble_d = mem_bubble | {LANES{flush}};
    pc_d     = mem_pc;
    res_d    = mem_res;
    rd_d     = mem_rd;
    w_rd_d   = '0;
    for (int l = 0; l < LANES; l++) w_rd_d[l] = mem_w_rd[l] && !bubble_d[l] && mem_rd[l] != '0;
  end
  // Youngest live lane writing cr updates it a cycle early; retire counts lanes now in WB
  always_comb begin
    cmp_d = cmp_q;
    for (int l = 0; l < LANES; l++)
      if (l == lane_pick(32'(mem_w_cr & ~bubble_d))) cmp_d = mem_cmp_res[l];
    instret_d = instret_q + 64'($countones(~bubble_q));
  end
  // Pipeline state; reset empties WB so nothing in flight commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q  <= '1;
      pc_q      <= '0;
      res_q     <= '0;
      rd_q      <= '0;
      w_rd_q    <= '0;
      cmp_q     <= '0;
      instret_q <= '0;
    end else begin
      bubble_q  <= bubble_d;
      pc_q      <= pc_d;
      res_q     <= res_d;
      rd_q      <= rd_d;
      w_rd_q    <= w_rd_d;
      cmp_q     <= cmp_d;
      instret_q <= instret_d;
    end
  end
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .LANES(LANES), .RPORTS(RPORTS)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_rd_q),
    .wa    (rd_q),
    .wd    (res_q),
    .ra    (rd_addr),
    .rdata (rd_data)
  );
  assign wb_bubble = bubble_q;
  assign wb_pc     = pc_q;
  assign wb_res    = res_q;
  assign wb_rd     = rd_q;
  assign wb_w_rd   = w_rd_q;
  assign cmp_reg   = cmp_q;
  assign instret   = instret_q;
endmodule

// File: tb/tb_stage_wb_mp.sv
// tb_stage_wb_mp: directed table-driven bench for the multi-lane writeback stage
module tb_stage_wb_mp;
  logic             clk, rst_n, flush;
  logic [1:0]       mem_bubble, mem_w_rd, mem_w_cr;
  logic [1:0][31:0] mem_pc, mem_res;
  logic [1:0][4:0]  mem_rd;
  logic [1:0][1:0]  mem_cmp_res;
  logic [1:0]       wb_bubble, wb_w_rd;
  logic [1:0][31:0] wb_pc, wb_res;
  logic [1:0][4:0]  wb_rd;
  logic [3:0][4:0]  rd_addr;
  logic [3:0][31:0] rd_data;
  logic [1:0]       cmp_reg;
  logic [63:0]      instret;
  int checks = 0;
  int errors = 0;

  stage_wb_mp dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mem_bubble(mem_bubble), .mem_pc(mem_pc), .mem_res(mem_res), .mem_rd(mem_rd),
    .mem_w_rd(mem_w_rd), .mem_w_cr(mem_w_cr), .mem_cmp_res(mem_cmp_res),
    .wb_bubble(wb_bubble), .wb_pc(wb_pc), .wb_res(wb_res), .wb_rd(wb_rd), .wb_w_rd(wb_w_rd),
    .rd_addr(rd_addr), .rd_data(rd_data), .cmp_reg(cmp_reg), .instret(instret)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        fl;
    logic [1:0]  bub, wrd, wcr;
    logic [4:0]  rd0, rd1;
    logic [31:0] r0, r1;
    logic [1:0]  c0, c1;
    logic [4:0]  ra;
    logic [1:0]  e_wrd, e_cmp;
    logic [63:0] e_ins;
    logic [31:0] e_data;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; mem_bubble = 2'b11; mem_w_rd = 0; mem_w_cr = 0;
    mem_pc = '0; mem_res = '0; mem_rd = '0; mem_cmp_res = '0;
  endtask

  initial begin
    vec[0]  = '{0, 2'b10, 2'b01, 2'b00, 5,  0,  32'hDEADBEEF, 0,     0, 0, 5,  2'b01, 0, 0, 32'hDEADBEEF};
    vec[1]  = '{0, 2'b11, 2'b00, 2'b00, 0,  0,  0,            0,     0, 0, 5,  2'b00, 0, 1, 32'hDEADBEEF};
    vec[2]  = '{0, 2'b00, 2'b11, 2'b11, 7,  7,  32'h11,       32'h22, 1, 3, 7, 2'b11, 3, 1, 32'h22};
    vec[3]  = '{0, 2'b11, 2'b00, 2'b00, 0,  0,  0,            0,     0, 0, 7,  2'b00, 3, 3, 32'h22};
    vec[4]  = '{0, 2'b01, 2'b10, 2'b01, 0,  0,  0,            32'h1234, 1, 0, 0, 2'b00, 3, 3, 0};
    vec[5]  = '{0, 2'b11, 2'b00, 2'b00, 0,  0,  0,            0,     0, 0, 0,  2'b00, 3, 4, 0};
    vec[6]  = '{1, 2'b00, 2'b11, 2'b10, 9,  10, 32'hAA,       32'hBB, 0, 2, 9, 2'b00, 3, 4, 0};
    vec[7]  = '{0, 2'b11, 2'b00, 2'b00, 0,  0,  0,            0,     0, 0, 10, 2'b00, 3, 4, 0};
    vec[8]  = '{0, 2'b00, 2'b00, 2'b01, 0,  0,  0,            0,     1, 0, 5,  2'b00, 1, 4, 32'hDEADBEEF};
    vec[9]  = '{0, 2'b00, 2'b01, 2'b00, 12, 12, 32'h1,        32'h99, 0, 0, 12, 2'b01, 1, 6, 32'h1};
    vec[10] = '{0, 2'b11, 2'b00, 2'b00, 0,  0,  0,            0,     0, 0, 12, 2'b00, 1, 8, 32'h1};

    idle();
    rd_addr = '0;
    rst_n = 1;
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset instret", instret, 0);
    chk("reset cmp_reg", cmp_reg, 0);
    chk("reset wb_bubble", wb_bubble, 2'b11);
    chk("reset wb_w_rd", wb_w_rd, 0);
    for (int b = 0; b < 32; b += 4) begin
      for (int p = 0; p < 4; p++) rd_addr[p] = 5'(b + p);
      #1;
      for (int p = 0; p < 4; p++) chk($sformatf("reset reg%0d", b + p), rd_data[p], 0);
    end

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      flush = vec[i].fl; mem_bubble = vec[i].bub; mem_w_rd = vec[i].wrd; mem_w_cr = vec[i].wcr;
      mem_rd[0] = vec[i].rd0; mem_rd[1] = vec[i].rd1;
      mem_res[0] = vec[i].r0; mem_res[1] = vec[i].r1;
      mem_pc[0] = 32'h1000 + 32'(i * 8); mem_pc[1] = 32'h1004 + 32'(i * 8);
      mem_cmp_res[0] = vec[i].c0; mem_cmp_res[1] = vec[i].c1;
      rd_addr = '0;
      rd_addr[i % 4] = vec[i].ra;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wb_bubble", i), wb_bubble, vec[i].bub | {2{vec[i].fl}});
      chk($sformatf("v%0d wb_w_rd", i), wb_w_rd, vec[i].e_wrd);
      chk($sformatf("v%0d cmp_reg", i), cmp_reg, vec[i].e_cmp);
      chk($sformatf("v%0d instret", i), instret, vec[i].e_ins);
      chk($sformatf("v%0d rd_data", i), rd_data[i % 4], vec[i].e_data);
      chk($sformatf("v%0d wb_pc1", i), wb_pc[1], 32'h1004 + 32'(i * 8));
    end

    @(negedge clk);
    idle();
    mem_bubble = 2'b10; mem_w_rd = 2'b01; mem_rd[0] = 20; mem_res[0] = 32'h55;
    rd_addr = '0; rd_addr[0] = 20; rd_addr[1] = 5;
    @(posedge clk);
    #1;
    chk("midrst bypass", rd_data[0], 32'h55);
    @(negedge clk);
    idle();
    rst_n = 0;
    #1;
    chk("midrst wb_bubble", wb_bubble, 2'b11);
    chk("midrst wb_w_rd", wb_w_rd, 0);
    chk("midrst instret", instret, 0);
    chk("midrst cmp_reg", cmp_reg, 0);
    chk("midrst reg20", rd_data[0], 0);
    chk("midrst reg5", rd_data[1], 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst reg20", rd_data[0], 0);
    chk("postrst instret", instret, 0);

    @(negedge clk);
    idle();
    mem_bubble = 2'b00;
    @(posedge clk);
    @(negedge clk);
    idle();
    force dut.instret_q = '1;
    #1 release dut.instret_q;
    #1 chk("wrap preset", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    chk("wrap instret", instret, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
